// File: rtl/wshb_stream_sink.sv
// Wishbone classic slave that sinks 32-bit pixel writes into a first-word-fall-through FIFO
// and replays them as a valid/ready pixel stream with start-of-frame / end-of-line markers.
module wshb_stream_sink #(
    parameter int DEPTH = 16,
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_ms,
    output logic [31:0] wb_dat_sm,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0] X_LAST     = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(VDISP - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   frames;

    logic req;
    logic is_ctrl;
    logic do_push;
    logic do_err;
    logic do_ctrl;
    logic do_read;
    logic do_flush;
    logic do_pop;
    logic unused_adr_bits;

    assign unused_adr_bits = ^{wb_adr[31:3], wb_adr[1:0]};

    // Free space is judged on the registered level only, so a same-cycle pop never frees a slot.
    always_comb begin
        req      = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
        is_ctrl  = wb_adr[2];
        do_err   = req & wb_we & ~is_ctrl & (wb_sel != 4'hF);
        do_push  = req & wb_we & ~is_ctrl & (wb_sel == 4'hF) & (level < LEVEL_FULL);
        do_ctrl  = req & wb_we & is_ctrl;
        do_read  = req & ~wb_we;
        do_flush = do_ctrl & wb_dat_ms[0];
        do_pop   = out_valid & out_ready & ~do_flush;
    end

    always_comb begin
        out_valid = (level != '0);
        out_data  = mem[rd_ptr];
        out_sof   = out_valid & (x == '0) & (y == '0);
        out_eol   = out_valid & (x == X_LAST);
        wb_rty    = 1'b0;
    end

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            wb_dat_sm <= '0;
        end else begin
            wb_ack <= do_push | do_ctrl | do_read;
            wb_err <= do_err;
            if (do_read) begin
                wb_dat_sm <= {frames, 16'(level)};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and level alone define what is valid.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wb_dat_ms;
        end
    end

    // Raster position of the head pixel; frames survives a flush.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            x      <= '0;
            y      <= '0;
            frames <= '0;
        end else if (do_flush) begin
            x <= '0;
            y <= '0;
        end else if (do_pop) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y      <= '0;
                    frames <= frames + 16'd1;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end
endmodule
